// File: rtl/adder_arbiter_if.sv
// Request/adder/response bundle for adder_arbiter; slave is the arbiter view, master the environment view.
// Optional macro ADDER_ARB_OVF_EN adds the rsp_ovf_out signal.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid_in;
    logic [32*NUM_REQ-1:0] req_data1_in;
    logic [32*NUM_REQ-1:0] req_data2_in;
    logic [NUM_REQ-1:0]    req_ready_out;
    logic [31:0]           add_data1_out;
    logic [31:0]           add_data2_out;
    logic [31:0]           add_sum_in;
    logic                  rsp_valid_out;
    logic [ID_W-1:0]       rsp_id_out;
    logic [31:0]           rsp_data_out;
    logic                  rsp_ready_in;
`ifdef ADDER_ARB_OVF_EN
    logic                  rsp_ovf_out;
`endif

    modport slave (
`ifdef ADDER_ARB_OVF_EN
        output rsp_ovf_out,
`endif
        input  req_valid_in, req_data1_in, req_data2_in, add_sum_in, rsp_ready_in,
        output req_ready_out, add_data1_out, add_data2_out,
               rsp_valid_out, rsp_id_out, rsp_data_out
    );

    modport master (
`ifdef ADDER_ARB_OVF_EN
        input  rsp_ovf_out,
`endif
        output req_valid_in, req_data1_in, req_data2_in, add_sum_in, rsp_ready_in,
        input  req_ready_out, add_data1_out, add_data2_out,
               rsp_valid_out, rsp_id_out, rsp_data_out
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one external 32-bit adder between NUM_REQ requesters, one result per cycle.
// Optional macro ADDER_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf_out).
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    adder_arbiter_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] grant_s;
    logic            any_valid_s;
    logic            accept_ok_s;
    logic            accept_s;
    logic [ID_W-1:0] rsp_id_r;
    logic [31:0]     rsp_data_r;
    logic [31:0]     op1_s [NUM_REQ];
    logic [31:0]     op2_s [NUM_REQ];

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
        logic          found;
        logic [ID_W:0] idx;
        rr_pick = {ID_W{1'b0}};
        found   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(off);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (!found && valid[idx[ID_W-1:0]]) begin
                rr_pick = idx[ID_W-1:0];
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
        rr_next = (g == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : g + ID_W'(1);
    endfunction

`ifdef ADDER_ARB_OVF_EN
    logic rsp_ovf_r;

    function automatic logic ovf_f(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s);
        ovf_f = (a[31] == b[31]) & (s[31] != a[31]);
    endfunction

    assign bus.rsp_ovf_out = rsp_ovf_r;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op1_s[i] = bus.req_data1_in[32*i +: 32];
        assign op2_s[i] = bus.req_data2_in[32*i +: 32];
    end

    // Nothing is granted while reset is held, so the bus stays quiet during reset.
    assign any_valid_s = |bus.req_valid_in;
    assign accept_ok_s = (state_r == IDLE) | bus.rsp_ready_in;
    assign accept_s    = any_valid_s & accept_ok_s & ~rst_i;
    assign grant_s     = rr_pick(bus.req_valid_in, rr_ptr_r);

    assign bus.rsp_id_out   = rsp_id_r;
    assign bus.rsp_data_out = rsp_data_r;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.rsp_ready_in) begin
                    state_nxt_s = accept_s ? BUSY : IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant, adder operand drive and response valid.
    always_comb begin
        bus.req_ready_out = {NUM_REQ{1'b0}};
        bus.add_data1_out = 32'h0;
        bus.add_data2_out = 32'h0;
        if (accept_s) begin
            bus.req_ready_out[grant_s] = 1'b1;
            bus.add_data1_out          = op1_s[grant_s];
            bus.add_data2_out          = op2_s[grant_s];
        end else begin
            bus.req_ready_out = {NUM_REQ{1'b0}};
        end
        bus.rsp_valid_out = (state_r == BUSY);
    end

    // Result capture and round-robin pointer; both hold when nothing is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r   <= {ID_W{1'b0}};
            rsp_id_r   <= {ID_W{1'b0}};
            rsp_data_r <= 32'h0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            rr_ptr_r   <= rr_next(grant_s);
            rsp_id_r   <= grant_s;
            rsp_data_r <= bus.add_sum_in;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_r  <= ovf_f(op1_s[grant_s], op2_s[grant_s], bus.add_sum_in);
`endif
        end else begin
            rr_ptr_r   <= rr_ptr_r;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Table-driven bench for adder_arbiter with a queue scoreboard for responses.
module tb_adder_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // External combinational adder.
    assign bus.add_sum_in = bus.add_data1_out + bus.add_data2_out;

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ready;
        logic        exp_valid;
    } vec_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            ovf;
    } exp_t;

    vec_t        tbl [17];
    exp_t        sb_q [$];
    logic [31:0] opa [NUM_REQ];
    logic [31:0] opb [NUM_REQ];
    logic [ID_W-1:0] last_id;
    logic [31:0] last_data;
    logic        last_ovf;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check grant before the edge, check response after it.
    task automatic apply(input int tag, input vec_t v);
        exp_t e;
        int   g;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = v.a + (32'(i) << 8);
            opb[i] = v.b;
        end
        bus.req_valid_in = v.valid;
        bus.req_data1_in = {opa[3], opa[2], opa[1], opa[0]};
        bus.req_data2_in = {opb[3], opb[2], opb[1], opb[0]};
        bus.rsp_ready_in = v.rdy;
        #1;
        chk($sformatf("v%0d_ready", tag), 32'(bus.req_ready_out), 32'(v.exp_ready));
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v.exp_ready[i]) g = i;
        end
        if (g >= 0) begin
            chk($sformatf("v%0d_add1", tag), bus.add_data1_out, opa[g]);
            chk($sformatf("v%0d_add2", tag), bus.add_data2_out, opb[g]);
            e.id   = ID_W'(g);
            e.data = opa[g] + opb[g];
            e.ovf  = (opa[g][31] == opb[g][31]) && (e.data[31] != opa[g][31]);
            sb_q.push_back(e);
        end else if (v.valid == 4'b0000) begin
            chk($sformatf("v%0d_add_idle", tag), bus.add_data1_out, 32'h0);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_rsp_valid", tag), 32'(bus.rsp_valid_out), 32'(v.exp_valid));
        if (g >= 0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL v%0d_sb_empty: got no queued result required one", tag);
            end else begin
                e         = sb_q.pop_front();
                last_id   = e.id;
                last_data = e.data;
                last_ovf  = e.ovf;
            end
        end
        chk($sformatf("v%0d_rsp_id", tag), 32'(bus.rsp_id_out), 32'(last_id));
        chk($sformatf("v%0d_rsp_data", tag), bus.rsp_data_out, last_data);
`ifdef ADDER_ARB_OVF_EN
        chk($sformatf("v%0d_rsp_ovf", tag), 32'(bus.rsp_ovf_out), 32'(last_ovf));
`endif
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        // Requester i gets operand a + 256*i so a wrong selection shows in the sum.
        tbl[0]  = '{4'b1111, 1'b1, 32'd100,        32'd1,  4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, 1'b1, 32'd100,        32'd1,  4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 32'd100,        32'd1,  4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 32'd100,        32'd1,  4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 32'd100,        32'd1,  4'b0001, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 32'd0,          32'd0,  4'b0000, 1'b0};
        tbl[6]  = '{4'b0010, 1'b1, 32'd5,          32'd7,  4'b0010, 1'b1};
        tbl[7]  = '{4'b0100, 1'b0, 32'd9,          32'd1,  4'b0000, 1'b1};
        tbl[8]  = '{4'b0100, 1'b0, 32'd9,          32'd1,  4'b0000, 1'b1};
        tbl[9]  = '{4'b0100, 1'b0, 32'd9,          32'd1,  4'b0000, 1'b1};
        tbl[10] = '{4'b0100, 1'b1, 32'd9,          32'd1,  4'b0100, 1'b1};
        tbl[11] = '{4'b0001, 1'b1, 32'hFFFF_FFFF,  32'd1,  4'b0001, 1'b1};
        tbl[12] = '{4'b0101, 1'b1, 32'h10,         32'h20, 4'b0100, 1'b1};
        tbl[13] = '{4'b0101, 1'b1, 32'h10,         32'h20, 4'b0001, 1'b1};
        tbl[14] = '{4'b0000, 1'b0, 32'd0,          32'd0,  4'b0000, 1'b1};
        tbl[15] = '{4'b0000, 1'b1, 32'd0,          32'd0,  4'b0000, 1'b0};
        tbl[16] = '{4'b0001, 1'b1, 32'h7FFF_FFFF,  32'd1,  4'b0001, 1'b1};

        rst              = 1'b1;
        bus.req_valid_in = 4'b1111;
        bus.req_data1_in = {4{32'h1}};
        bus.req_data2_in = {4{32'h2}};
        bus.rsp_ready_in = 1'b1;
        last_id          = {ID_W{1'b0}};
        last_data        = 32'h0;
        last_ovf         = 1'b0;

        // Reset held two cycles with every requester valid.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d_ready", c), 32'(bus.req_ready_out), 32'h0);
            chk($sformatf("rst%0d_valid", c), 32'(bus.rsp_valid_out), 32'h0);
        end
        chk("rst_id", 32'(bus.rsp_id_out), 32'h0);
        chk("rst_data", bus.rsp_data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(i, tbl[i]);
        end

        // Reset while a result is held and the consumer is stalled.
        bus.req_valid_in = 4'b0000;
        bus.rsp_ready_in = 1'b0;
        rst              = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid_out), 32'h0);
        chk("midrst_id", 32'(bus.rsp_id_out), 32'h0);
        chk("midrst_data", bus.rsp_data_out, 32'h0);
`ifdef ADDER_ARB_OVF_EN
        chk("midrst_ovf", 32'(bus.rsp_ovf_out), 32'h0);
`endif
        last_id   = {ID_W{1'b0}};
        last_data = 32'h0;
        last_ovf  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Pointer back at 0: requester 0 wins although the last grant was requester 0.
        v = '{4'b1111, 1'b1, 32'd3, 32'd4, 4'b0001, 1'b1};
        apply(100, v);
        v = '{4'b1111, 1'b1, 32'd3, 32'd4, 4'b0010, 1'b1};
        apply(101, v);
        v = '{4'b0000, 1'b1, 32'd0, 32'd0, 4'b0000, 1'b0};
        apply(102, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
